// File: rtl/v_writeback.sv
// Vector writeback sequencer: takes two-lane beats (ALU or MUL results) and
// writes them into consecutive vector registers of an LMUL group, one register per cycle.
module v_writeback #(
  parameter int VLEN = 128,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            start,
  input  logic [4:0]      vd,
  input  logic [2:0]      lmul,
  input  logic            res_sel,
  input  logic            done,
  input  logic [VLEN-1:0] result_valu_1,
  input  logic [VLEN-1:0] result_vmul_1,
  input  logic [VLEN-1:0] result_valu_2,
  input  logic [VLEN-1:0] result_vmul_2,
  output logic            in_ready,
  output logic            wr_en,
  output logic [4:0]      wr_addr,
  output logic [VLEN-1:0] wr_data,
  output logic            busy,
  output logic            wb_done,
  output logic            lmul_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BEAT = 3'd1,
    WR_LO     = 3'd2,
    WR_HI     = 3'd3,
    FIN       = 3'd4
  } state_t;

  localparam logic [4:0] ADDR_MASK = 5'(NREG - 1);

  state_t          state;
  logic [4:0]      vd_q;
  logic [1:0]      lmul_q;
  logic            sel_q;
  logic [1:0]      beat;
  logic [VLEN-1:0] buf_lo;
  logic [VLEN-1:0] buf_hi;
  logic [4:0]      addr_c;

  // Index of the final beat: one beat carries two registers, except lmul=0 (one register).
  function automatic logic [1:0] last_beat(input logic [1:0] lm);
    case (lm)
      2'd2:    return 2'd1;
      2'd3:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      vd_q     <= '0;
      lmul_q   <= '0;
      sel_q    <= 1'b0;
      beat     <= '0;
      buf_lo   <= '0;
      buf_hi   <= '0;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      wb_done  <= 1'b0;
      lmul_err <= 1'b0;
    end else begin
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wb_done  <= 1'b0;
      lmul_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (lmul[2]) begin
              lmul_err <= 1'b1;
            end else begin
              vd_q     <= vd;
              lmul_q   <= lmul[1:0];
              sel_q    <= res_sel;
              beat     <= '0;
              busy     <= 1'b1;
              in_ready <= 1'b1;
              state    <= WAIT_BEAT;
            end
          end
        end
        WAIT_BEAT: begin
          if (done) begin
            buf_lo <= sel_q ? result_vmul_1 : result_valu_1;
            buf_hi <= sel_q ? result_vmul_2 : result_valu_2;
            wr_en  <= 1'b1;
            state  <= WR_LO;
          end else begin
            in_ready <= 1'b1;
          end
        end
        WR_LO: begin
          if (lmul_q == 2'd0) begin
            wb_done <= 1'b1;
            state   <= FIN;
          end else begin
            wr_en <= 1'b1;
            state <= WR_HI;
          end
        end
        WR_HI: begin
          if (beat == last_beat(lmul_q)) begin
            wb_done <= 1'b1;
            state   <= FIN;
          end else begin
            beat     <= beat + 2'd1;
            in_ready <= 1'b1;
            state    <= WAIT_BEAT;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write port is decoded from the buffer; address wraps around the register file.
  always_comb begin
    addr_c  = (vd_q + {2'b00, beat, 1'b0} + {4'b0000, (state == WR_HI)}) & ADDR_MASK;
    wr_addr = '0;
    wr_data = '0;
    if (wr_en) begin
      wr_addr = addr_c;
      wr_data = (state == WR_HI) ? buf_hi : buf_lo;
    end
  end

endmodule

// File: tb/tb_v_writeback.sv
// Directed-sequence bench for v_writeback with random lane data; expected
// addresses/data/timing are derived from group size arithmetic in the bench.
module tb_v_writeback;
  localparam int VLEN = 128;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            start = 1'b0;
  logic [4:0]      vd = '0;
  logic [2:0]      lmul = '0;
  logic            res_sel = 1'b0;
  logic            done = 1'b0;
  logic [VLEN-1:0] valu1 = '0, vmul1 = '0, valu2 = '0, vmul2 = '0;
  logic            in_ready, wr_en, busy, wb_done, lmul_err;
  logic [4:0]      wr_addr;
  logic [VLEN-1:0] wr_data;

  int n_chk = 0, n_err = 0;
  int n_wr = 0, n_beat = 0, n_wbd = 0, n_lerr = 0;
  int exp_wr = 0, exp_beat = 0, exp_wbd = 0, exp_lerr = 0;

  v_writeback #(.VLEN(VLEN), .NREG(32)) dut (
    .clk(clk), .nrst(nrst), .start(start), .vd(vd), .lmul(lmul), .res_sel(res_sel),
    .done(done), .result_valu_1(valu1), .result_vmul_1(vmul1),
    .result_valu_2(valu2), .result_vmul_2(vmul2), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .wb_done(wb_done), .lmul_err(lmul_err)
  );

  always #5 clk = ~clk;

  // Event counters observed at the clock edge (values before the edge update).
  always @(posedge clk) begin
    if (wr_en) n_wr++;
    if (done && in_ready) n_beat++;
    if (wb_done) n_wbd++;
    if (lmul_err) n_lerr++;
  end

  function automatic logic [VLEN-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_inputs();
    valu1 = rnd128(); vmul1 = rnd128(); valu2 = rnd128(); vmul2 = rnd128();
  endtask

  // One full group: start, nb beats, writes checked cycle by cycle, wb_done, back to idle.
  task automatic run_group(input logic [4:0] g_vd, input int g_lmul, input logic g_sel,
                           input int gap, input bit hold, input bit poke, input bit aa);
    int nb;
    logic [VLEN-1:0] e1, e2;
    logic [4:0] a;
    nb = (g_lmul == 0) ? 1 : (1 << (g_lmul - 1));
    @(negedge clk);
    start = 1'b1; vd = g_vd; lmul = 3'(g_lmul); res_sel = g_sel;
    @(negedge clk);
    start = 1'b0; vd = ~g_vd; lmul = 3'd0; res_sel = ~g_sel;
    chk("grp_busy", busy, 1);
    chk("grp_rdy0", in_ready, 1);
    for (int b = 0; b < nb; b++) begin
      for (int g = 0; g < gap; g++) begin
        start = poke && (b == 0) && (g == 0);
        vd = g_vd + 5'd7;
        @(negedge clk);
        start = 1'b0;
        chk("gap_rdy", in_ready, 1);
        chk("gap_wr", wr_en, 0);
      end
      rand_inputs();
      if (aa) vmul1 = {16{8'hAA}};
      e1 = g_sel ? vmul1 : valu1;
      e2 = g_sel ? vmul2 : valu2;
      done = 1'b1;
      @(negedge clk);
      if (!hold) done = 1'b0;
      rand_inputs();
      a = 5'(int'(g_vd) + 2 * b);
      chk("lo_en", wr_en, 1);
      chk("lo_addr", wr_addr, a);
      chk("lo_data", wr_data, e1);
      chk("lo_rdy", in_ready, 0);
      if (g_lmul != 0) begin
        @(negedge clk);
        rand_inputs();
        chk("hi_en", wr_en, 1);
        chk("hi_addr", wr_addr, 5'(a + 5'd1));
        chk("hi_data", wr_data, e2);
        chk("hi_rdy", in_ready, 0);
      end
      @(negedge clk);
      if (b < nb - 1) begin
        chk("next_rdy", in_ready, 1);
        chk("next_wr", wr_en, 0);
      end
    end
    chk("fin_done", wb_done, 1);
    chk("fin_wr", wr_en, 0);
    chk("fin_addr", wr_addr, 0);
    chk("fin_busy", busy, 1);
    done = 1'b0;
    @(negedge clk);
    chk("idle_done", wb_done, 0);
    chk("idle_busy", busy, 0);
    exp_wr += (g_lmul == 0) ? 1 : 2 * nb;
    exp_beat += nb;
    exp_wbd++;
  endtask

  initial begin
    rand_inputs();
    repeat (3) @(negedge clk);
    chk("rst_rdy", in_ready, 0);
    chk("rst_wr", wr_en, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wbd", wb_done, 0);
    chk("rst_lerr", lmul_err, 0);
    nrst = 1'b1;

    run_group(5'd5, 0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    run_group(5'd8, 2, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    run_group(5'd31, 1, 1'($urandom), 0, 1'b0, 1'b0, 1'b0);
    run_group(5'($urandom), 3, 1'($urandom), 0, 1'b1, 1'b0, 1'b0);

    // Illegal lmul values.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b1; vd = 5'd9; lmul = (k == 0) ? 3'd5 : 3'd7;
      @(negedge clk);
      start = 1'b0; lmul = 3'd0;
      chk("lerr_pulse", lmul_err, 1);
      chk("lerr_busy", busy, 0);
      chk("lerr_wr", wr_en, 0);
      chk("lerr_rdy", in_ready, 0);
      @(negedge clk);
      chk("lerr_clear", lmul_err, 0);
      exp_lerr++;
    end

    run_group(5'd8, 1, 1'b0, 2, 1'b0, 1'b1, 1'b0);

    for (int r = 0; r < 8; r++)
      run_group(5'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                int'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b0);

    // Reset between the two writes of a beat aborts the group.
    @(negedge clk);
    start = 1'b1; vd = 5'd3; lmul = 3'd1; res_sel = 1'b0;
    @(negedge clk);
    start = 1'b0;
    rand_inputs();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("abort_lo_en", wr_en, 1);
    chk("abort_lo_addr", wr_addr, 5'd3);
    nrst = 1'b0; start = 1'b1; done = 1'b1;
    @(negedge clk);
    chk("abort_wr", wr_en, 0);
    chk("abort_addr", wr_addr, 0);
    chk("abort_data", wr_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rdy", in_ready, 0);
    chk("abort_wbd", wb_done, 0);
    nrst = 1'b1; start = 1'b0; done = 1'b0;
    exp_wr += 1;
    exp_beat += 1;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_wbd", wb_done, 0);
      chk("post_abort_wr", wr_en, 0);
    end

    run_group(5'd20, 2, 1'b1, 0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    chk("tot_writes", n_wr, exp_wr);
    chk("tot_beats", n_beat, exp_beat);
    chk("tot_wbdone", n_wbd, exp_wbd);
    chk("tot_lmulerr", n_lerr, exp_lerr);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
